// File: rtl/lif_neuron_multi.sv
// Multi-synapse leaky integrate-and-fire neuron with saturation and refractory hold; LIF_SOFT_RESET_EN selects subtract-threshold reset on fire.
// Latency: 2 cycles step_valid -> out_valid; no backpressure, accepts a step every cycle.
module lif_neuron_multi #(
    parameter int NUM_SYN  = 4,
    parameter int WEIGHT_W = 8,
    parameter int POT_W    = 16,
    parameter int LEAK_W   = 8,
    parameter int REFRAC_W = 4,
    parameter logic signed [POT_W-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        step_valid,
    input  logic [NUM_SYN-1:0]          in_spikes,
    input  logic [NUM_SYN*WEIGHT_W-1:0] weights,
    input  logic [LEAK_W-1:0]           leak_factor,
    input  logic [POT_W-1:0]            threshold,
    input  logic [REFRAC_W-1:0]         refrac_period,
    output logic                        out_valid,
    output logic                        out_spike,
    output logic [POT_W-1:0]            potential,
    output logic                        in_refrac
);

    localparam int SUM_W = WEIGHT_W + $clog2(NUM_SYN) + 1;
    localparam int EXT_W = POT_W + 2;

    // Clamp an extended-width value into the signed POT_W range.
    function automatic logic [POT_W-1:0] f_sat(input logic [EXT_W-1:0] v);
        logic [EXT_W-POT_W:0] top;
        top = v[EXT_W-1:POT_W-1];
        if (top == '0 || top == '1)
            return v[POT_W-1:0];
        else if (v[EXT_W-1])
            return {1'b1, {(POT_W-1){1'b0}}};
        else
            return {1'b0, {(POT_W-1){1'b1}}};
    endfunction

    logic [SUM_W-1:0]    w_syn_sum;
    logic                r_s1_vld;
    logic [SUM_W-1:0]    r_s1_sum;
    logic [LEAK_W-1:0]   r_s1_leak;
    logic [POT_W-1:0]    r_s1_thr;
    logic [POT_W-1:0]    r_pot;
    logic [REFRAC_W-1:0] r_cnt;
    logic                r_out_valid;
    logic                r_out_spike;
    logic [EXT_W-1:0]    w_v_raw;
    logic [POT_W-1:0]    w_v_sat;
    logic                w_fire;
    logic [POT_W-1:0]    w_fire_pot;

    always_comb begin
        w_syn_sum = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (in_spikes[i])
                w_syn_sum = w_syn_sum + {{(SUM_W-WEIGHT_W){weights[i*WEIGHT_W+WEIGHT_W-1]}},
                                         weights[i*WEIGHT_W +: WEIGHT_W]};
        end
    end

    assign w_v_raw = {{2{r_pot[POT_W-1]}}, r_pot}
                   + {{(EXT_W-SUM_W){r_s1_sum[SUM_W-1]}}, r_s1_sum}
                   - {{(EXT_W-LEAK_W){1'b0}}, r_s1_leak};
    assign w_v_sat = f_sat(w_v_raw);
    assign w_fire  = $signed(w_v_sat) >= $signed(r_s1_thr);

`ifdef LIF_SOFT_RESET_EN
    logic [EXT_W-1:0] w_resid_raw;
    assign w_resid_raw = {{2{w_v_sat[POT_W-1]}}, w_v_sat} - {{2{r_s1_thr[POT_W-1]}}, r_s1_thr};
    assign w_fire_pot  = f_sat(w_resid_raw);
`else
    assign w_fire_pot  = RESET_VAL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_leak   <= '0;
            r_s1_thr    <= '0;
            r_pot       <= RESET_VAL;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_spike <= 1'b0;
        end else begin
            r_s1_vld <= step_valid;
            if (step_valid) begin
                r_s1_sum  <= w_syn_sum;
                r_s1_leak <= leak_factor;
                r_s1_thr  <= threshold;
            end
            r_out_valid <= r_s1_vld;
            r_out_spike <= 1'b0;
            // Refractory steps only count down; potential and inputs are untouched.
            if (r_s1_vld) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - REFRAC_W'(1);
                end else if (w_fire) begin
                    r_out_spike <= 1'b1;
                    r_pot       <= w_fire_pot;
                    r_cnt       <= refrac_period;
                end else begin
                    r_pot <= w_v_sat;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_spike = r_out_spike;
    assign potential = r_pot;
    assign in_refrac = (r_cnt != '0);

endmodule
